// File: rtl/store_commit_buffer.sv
// Store commit buffer: holds committed stores in a circular queue and drains
// them one at a time into the data memory write port. Speculative loads are
// checked against every queued store; a full-word match is forwarded and a
// partial (byte/half) match asks the load to stall.
module store_commit_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  // ROB commit-store handshake
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [AW-1:0]                st_addr,
  input  logic [2:0]                   st_funct3,
  input  logic [31:0]                  st_data,
  // data memory write port
  output logic                         mem_we,
  output logic [AW-1:0]                mem_addr,
  output logic [2:0]                   mem_funct3,
  output logic [31:0]                  mem_wdata,
  input  logic                         mem_ready,
  // speculative load lookup
  input  logic                         ld_valid,
  input  logic [AW-1:0]                ld_addr,
  input  logic [2:0]                   ld_funct3,
  output logic                         fwd_hit,
  output logic [31:0]                  fwd_data,
  output logic                         ld_stall,
  // occupancy
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  // Entry storage (never reset; validity comes from head/count)
  logic [AW-1:0] r_ent_addr [DEPTH];
  logic [2:0]    r_ent_f3   [DEPTH];
  logic [31:0]   r_ent_data [DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] w_count_next;

  logic          w_legal;
  logic          w_enq;
  logic          w_retire;

  logic [PW-1:0]    w_age [DEPTH];
  logic [DEPTH-1:0] w_match;
  logic             w_found;
  logic [PW-1:0]    w_best_idx;
  logic [PW-1:0]    w_best_age;
  logic [31:0]      w_best_word;

  assign st_ready = (r_count < FULL_C);
  assign empty    = (r_count == '0);
  assign count    = r_count;

  // Unknown store widths complete the handshake but never occupy a slot.
  assign w_legal  = (st_funct3 == F3_SB) || (st_funct3 == F3_SH) || (st_funct3 == F3_SW);
  assign w_enq    = st_valid && st_ready && w_legal;
  assign w_retire = (r_state == S_WRITE) && mem_ready;

  // Occupancy update: simultaneous enqueue and retire cancel out
  always_comb begin
    w_count_next = r_count;
    if (w_enq && !w_retire)
      w_count_next = r_count + CW'(1);
    else if (!w_enq && w_retire)
      w_count_next = r_count - CW'(1);
  end

  // Pointer and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_enq)
        r_tail <= r_tail + PW'(1);
      if (w_retire)
        r_head <= r_head + PW'(1);
    end
  end

  // Entry write at the tail slot
  always_ff @(posedge clk) begin
    if (w_enq && !reset) begin
      r_ent_addr[r_tail] <= st_addr;
      r_ent_f3[r_tail]   <= st_funct3;
      r_ent_data[r_tail] <= st_data;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  // FSM next state and memory port drive; head entry is presented while writing
  always_comb begin
    w_state_next = r_state;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_funct3   = '0;
    mem_wdata    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_count_next != '0)
          w_state_next = S_WRITE;
      end
      S_WRITE: begin
        mem_we     = 1'b1;
        mem_addr   = r_ent_addr[r_head];
        mem_funct3 = r_ent_f3[r_head];
        mem_wdata  = r_ent_data[r_head];
        if (w_count_next == '0)
          w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Per-slot age (0 = head/oldest) and address match against occupied slots.
  // Uses the registered count, so a store entering this cycle is not seen.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign w_age[gi]   = PW'(gi) - r_head;
      assign w_match[gi] = (CW'(w_age[gi]) < r_count) && (r_ent_addr[gi] == ld_addr);
    end
  endgenerate

  // Pick the youngest matching slot
  always_comb begin
    w_found    = 1'b0;
    w_best_idx = '0;
    w_best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_match[i] && (!w_found || (w_age[i] > w_best_age))) begin
        w_found    = 1'b1;
        w_best_idx = PW'(i);
        w_best_age = w_age[i];
      end
    end
  end

  assign w_best_word = r_ent_data[w_best_idx];

  // Forward a full-word match formatted by load width; partial matches stall
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    ld_stall = 1'b0;
    if (ld_valid && w_found) begin
      if (r_ent_f3[w_best_idx] == F3_SW) begin
        case (ld_funct3)
          F3_SB: begin
            fwd_hit  = 1'b1;
            fwd_data = {{24{w_best_word[7]}}, w_best_word[7:0]};
          end
          F3_SH: begin
            fwd_hit  = 1'b1;
            fwd_data = {{16{w_best_word[15]}}, w_best_word[15:0]};
          end
          F3_SW: begin
            fwd_hit  = 1'b1;
            fwd_data = w_best_word;
          end
          F3_LBU: begin
            fwd_hit  = 1'b1;
            fwd_data = {24'h0, w_best_word[7:0]};
          end
          F3_LHU: begin
            fwd_hit  = 1'b1;
            fwd_data = {16'h0, w_best_word[15:0]};
          end
          default: begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
          end
        endcase
      end else begin
        ld_stall = 1'b1;
      end
    end
  end

endmodule
